// File: rtl/requant_packer.sv
// Post-MAC output stage: restores the VSQ scale shift, requantizes each 24-bit result by a
// rounding arithmetic right shift, saturates it to INT8/INT4 and packs the lanes into 256-bit words.
module requant_packer (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [1:0]   i_mode,
  input  logic [4:0]   i_shift,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [23:0]  i_result,
  input  logic         i_last,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [255:0] o_data,
  output logic [6:0]   o_count,
  output logic         o_last,
  output logic [15:0]  o_sat_cnt
);
  localparam int unsigned DATA_W  = 256;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned SAT_W   = 16;
  localparam int unsigned ACC_W   = 33;
  localparam int unsigned RES_W   = 24;
  localparam int unsigned SHAMT_W = 9;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]        state, state_nx;
  logic [CNT_W-1:0]  lane_idx, lane_idx_nx;
  logic [1:0]        word_mode, word_mode_nx;
  logic [4:0]        word_shift, word_shift_nx;
  logic [DATA_W-1:0] pack, pack_nx;
  logic [CNT_W-1:0]  pack_count, pack_count_nx;
  logic              pack_last, pack_last_nx;
  logic              ready_nx, valid_nx, last_nx;
  logic [DATA_W-1:0] data_nx;
  logic [CNT_W-1:0]  count_nx;
  logic [SAT_W-1:0]  sat_cnt_nx;

  logic [1:0]              cur_mode;
  logic [4:0]              cur_shift;
  logic                    is_int8;
  logic signed [ACC_W-1:0] x_ext, x, rnd, r, sat_hi, sat_lo;
  logic                    lane_sat;
  logic [7:0]              lane_val;
  logic [SHAMT_W-1:0]      shamt;
  logic [DATA_W-1:0]       word_c;
  logic [CNT_W-1:0]        lane_cnt;
  logic                    lane_done, accept, out_free;

  // Lane datapath; lane 0 uses the live mode/shift since that is where they get latched
  always_comb begin
    cur_mode  = (lane_idx == '0) ? i_mode  : word_mode;
    cur_shift = (lane_idx == '0) ? i_shift : word_shift;
    is_int8   = (cur_mode == 2'd0);
    x_ext     = {{(ACC_W-RES_W){i_result[RES_W-1]}}, i_result};
    x         = cur_mode[1] ? (x_ext <<< 8) : x_ext;
    rnd       = (cur_shift == 5'd0) ? '0 : (ACC_W'(1) <<< (cur_shift - 5'd1));
    r         = (x + rnd) >>> cur_shift;
    sat_hi    = is_int8 ? 33'sd127 : 33'sd7;
    sat_lo    = is_int8 ? -33'sd128 : -33'sd8;
    lane_sat  = (r > sat_hi) || (r < sat_lo);
    if (r > sat_hi)      lane_val = sat_hi[7:0];
    else if (r < sat_lo) lane_val = sat_lo[7:0];
    else                 lane_val = r[7:0];
    if (!is_int8) lane_val = {4'h0, lane_val[3:0]};
    shamt     = is_int8 ? (SHAMT_W'(lane_idx) << 3) : (SHAMT_W'(lane_idx) << 2);
    word_c    = pack | (DATA_W'(lane_val) << shamt);
    lane_cnt  = lane_idx + CNT_W'(1);
    lane_done = i_last || (lane_cnt == (is_int8 ? CNT_W'(32) : CNT_W'(64)));
    out_free  = !o_valid || i_ready;
    accept    = i_valid && (state == ST_FILL);
  end

  // Next-state and output-register logic
  always_comb begin
    state_nx      = state;
    lane_idx_nx   = lane_idx;
    word_mode_nx  = word_mode;
    word_shift_nx = word_shift;
    pack_nx       = pack;
    pack_count_nx = pack_count;
    pack_last_nx  = pack_last;
    data_nx       = o_data;
    count_nx      = o_count;
    last_nx       = o_last;
    valid_nx      = o_valid;
    sat_cnt_nx    = o_sat_cnt;

    if (o_valid && i_ready) valid_nx = 1'b0;

    case (state)
      ST_FILL: begin
        if (accept) begin
          if (lane_idx == '0) begin
            word_mode_nx  = cur_mode;
            word_shift_nx = cur_shift;
          end
          if (lane_sat && (o_sat_cnt != '1)) sat_cnt_nx = o_sat_cnt + SAT_W'(1);
          if (lane_done && out_free) begin
            data_nx     = word_c;
            count_nx    = lane_cnt;
            last_nx     = i_last;
            valid_nx    = 1'b1;
            pack_nx     = '0;
            lane_idx_nx = '0;
          end else if (lane_done) begin
            pack_nx       = word_c;
            pack_count_nx = lane_cnt;
            pack_last_nx  = i_last;
            state_nx      = ST_FULL;
          end else begin
            pack_nx     = word_c;
            lane_idx_nx = lane_cnt;
          end
        end
      end
      ST_FULL: begin
        if (out_free) begin
          data_nx     = pack;
          count_nx    = pack_count;
          last_nx     = pack_last;
          valid_nx    = 1'b1;
          pack_nx     = '0;
          lane_idx_nx = '0;
          state_nx    = ST_FILL;
        end
      end
      default: state_nx = ST_FILL;
    endcase

    ready_nx = (state_nx == ST_FILL);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_FILL;
      lane_idx   <= '0;
      word_mode  <= '0;
      word_shift <= '0;
      pack       <= '0;
      pack_count <= '0;
      pack_last  <= 1'b0;
      o_ready    <= 1'b1;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_count    <= '0;
      o_last     <= 1'b0;
      o_sat_cnt  <= '0;
    end else begin
      state      <= state_nx;
      lane_idx   <= lane_idx_nx;
      word_mode  <= word_mode_nx;
      word_shift <= word_shift_nx;
      pack       <= pack_nx;
      pack_count <= pack_count_nx;
      pack_last  <= pack_last_nx;
      o_ready    <= ready_nx;
      o_valid    <= valid_nx;
      o_data     <= data_nx;
      o_count    <= count_nx;
      o_last     <= last_nx;
      o_sat_cnt  <= sat_cnt_nx;
    end
  end
endmodule

// File: doc/requant_packer.md
# requant_packer

Post-MAC output stage that consumes the 24-bit per-dot-product result stream produced by the MAC array and turns it into packed 256-bit activation words. For INT4_VSQ results it restores the deferred 8-bit scale left shift. It then requantizes each result by a rounding arithmetic right shift, saturates it to INT8 or INT4, and packs 32 (INT8) or 64 (INT4) lanes per word. Words go to the activation buffer under valid/ready handshakes on both sides.

## Interface
Parameters: none. Lane widths and counts are fixed by mode.

- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_mode  in  2  0 = INT8, 1 = INT4, 2 = INT4_VSQ (3 treated as INT4_VSQ); latched at lane 0 of each word
- i_shift  in  5  requant right-shift amount 0..31; latched at lane 0 of each word
- i_valid  in  1  input result valid
- o_ready  out  1  input can be accepted this cycle
- i_result  in  24  signed MAC result (psum + dot product)
- i_last  in  1  final result of the tile; forces flush of the current word
- o_valid  out  1  output word valid
- i_ready  in  1  downstream accepts word
- o_data  out  256  packed lanes; lane k at bits [k*W +: W], W = 8 or 4
- o_count  out  7  number of populated lanes in o_data, 1..64
- o_last  out  1  word was closed by i_last
- o_sat_cnt  out  16  count of saturated lanes since reset; sticks at 16'hFFFF

## Operation
- Accept happens on a rising edge with i_valid && o_ready. Hold i_valid/i_result/i_last stable until accepted.
- Lane 0 accept latches i_mode and i_shift into word_mode/word_shift. Changes to i_mode/i_shift mid-word are ignored.
- Per-lane arithmetic, all in 33-bit signed:
  - x = sext(i_result), or sext(i_result) << 8 when word_mode is VSQ.
  - r = (word_shift == 0) ? x : (x + (1 << (word_shift-1))) >>> word_shift (round half up).
  - Saturate r to [-128, 127] in INT8 or [-8, 7] in INT4/VSQ. Keep the two's-complement low W bits.
  - A lane counts as saturated when r is outside the range. o_sat_cnt increments by 1 per saturated lane, no wrap.
- Packing: the lane is written at index lane_idx of the pack register, then lane_idx increments.
  - A word completes when lane_idx reaches N (32 INT8 / 64 INT4) or when the lane carries i_last.
  - Unpopulated lanes are 0.
- States:
  - FILL: o_ready = 1. On a completing accept:
    - If out_free (= !o_valid || i_ready), the completed word, including the new lane, loads directly into the output register. lane_idx = 0 and the state stays FILL.
    - Otherwise the word stays in the pack register and the state goes to FULL.
  - FULL: o_ready = 0. When out_free, the pack register transfers to the output register, the pack register clears, lane_idx = 0, and the state goes to FILL.
- Output handshake: a transfer occurs on i_ready && o_valid.
  - While o_valid is high, o_data/o_count/o_last are stable until the transfer.
  - On a transfer edge with no new word loading, o_valid drops to 0.
  - A transfer and a new load on the same edge keep o_valid = 1 with the new word.
- o_ready depends only on state, with no combinational path from i_ready.
- Reset is asynchronous. In-flight lanes and any unsent word are discarded, with no partial flush.

## Timing
- Reset values:
  - o_valid = 0, o_data = 0, o_count = 0, o_last = 0, o_sat_cnt = 0.
  - State = FILL, so o_ready = 1 during and after reset. lane_idx = 0.
- Latency: the word's final accept at edge t gives o_valid = 1 after edge t, when out_free.
- Throughput: 1 result/cycle sustained when i_ready is held high.
- When a word completes into a busy output register, o_ready is low from the cycle after that edge until the cycle after the FULL-to-output transfer edge.
- i_last on lane 0 emits a 1-lane word with o_count = 1.

## Test plan
- INT8, shift 0, results 0..31 with i_ready = 1 → one word with lane k = k, o_count = 32, o_last = 0, o_valid high for exactly 1 cycle, starting the cycle after the 32nd accept.
- INT8, shift 0, results 24'h000200 and 24'hFFFE00 with i_last on the second → lanes 0x7F and 0x80, o_count = 2, o_last = 1, o_sat_cnt = 2.
- INT4_VSQ rounding:
  - result 1, shift 7 → lane 0x2.
  - result -3, shift 9 → lane 0xF.
  - result 3, shift 4 → lane 0x7 (saturated).
- INT4, results 1..5 with i_last on 5 → o_data = 256'h54321, o_count = 5, o_last = 1.
- Backpressure: INT4, i_ready = 0, stream 128 results:
  - o_ready drops after the 128th accept.
  - Raise i_ready: word 0 transfers, word 1 appears the next cycle, and o_ready returns to 1.
- Reset mid-word: assert i_rst after 10 INT8 accepts → o_valid = 0 and o_sat_cnt = 0 immediately. The next 32 accepts form a fresh word starting at lane 0, and mode is re-latched.
